demux_route_ctrl: RTL

//   Upstream driver for the 1-to-4 demultiplexer: accepts routing requests {data bit, destination}

---
 rtl/demux_route_ctrl_pkg.sv | 34 +++
 rtl/demux_route_ctrl_route_fifo.sv | 89 ++++++++
 rtl/demux_route_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/demux_route_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// demux_route_ctrl_pkg
//   Shared definitions for the demux routing controller:
//     - FSM state encoding (ST_IDLE / ST_DRIVE)
//     - FIFO entry width and packed entry layout {data, dest}
//     - channel index constants CH0..CH3
//     - saturating 8-bit increment used by the optional delivery counters
// -----------------------------------------------------------------------------
package demux_route_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } route_state_e;

    localparam int ENTRY_W = 3;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    // One queued routing request; data bit sits above the destination.
    typedef struct packed {
        logic       data;
        logic [1:0] dest;
    } route_entry_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/demux_route_ctrl_route_fifo.sv
// -----------------------------------------------------------------------------
// route_fifo
//   Synchronous FIFO for routing requests. The head entry is presented
//   combinationally on rd_data so the consumer can load it at the same edge
//   it pops. Pushes while full and pops while empty are ignored.
// Parameters
//   DEPTH  entries, power of two, >= 2
//   WIDTH  entry width in bits
// Ports
//   clk      in   clock, all logic on posedge
//   rst_n    in   synchronous active-low reset (flushes pointers and count)
//   push     in   write wr_data at this edge (ignored when full)
//   wr_data  in   entry to write
//   pop      in   drop the head entry at this edge (ignored when empty)
//   rd_data  out  current head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module route_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// demux_route_ctrl
//   Upstream driver for a 1-to-4 demultiplexer. Routing requests {data, dest}
//   are accepted over valid/ready, queued in route_fifo, and each is held on
//   data_in/sel for HOLD_CYCLES cycles. Queued requests follow each other with
//   no idle gap; data_in returns to 0 when nothing is pending (sel keeps its
//   last value).
// Optional feature (macro ROUTE_STATS_EN): four saturating 8-bit per-channel
//   delivery counters exported as stat_cnt = {ch3, ch2, ch1, ch0}.
// Parameters
//   DEPTH        FIFO entries, power of two, >= 2
//   HOLD_CYCLES  cycles each request is held, >= 1
// Ports
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous active-low reset; drops current and queued requests
//   req_valid  in   request present
//   req_ready  out  FIFO can accept (not full)
//   req_data   in   bit to steer
//   req_dest   in   destination channel 0..3
//   data_in    out  to demux data_in
//   sel        out  to demux sel
//   busy       out  a request is currently being driven
//   count      out  FIFO occupancy
//   stat_cnt   out  (ROUTE_STATS_EN only) per-channel delivery counts
// -----------------------------------------------------------------------------
module demux_route_ctrl
    import demux_route_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_data,
    input  logic [1:0]               req_dest,
    output logic                     data_in,
    output logic [1:0]               sel,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
`ifdef ROUTE_STATS_EN
    ,
    output logic [31:0]              stat_cnt
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    route_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              data_in_q, data_in_d;
    logic [1:0]        sel_q, sel_d;

    route_entry_t      fifo_wr, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_wr   = '{data: req_data, dest: req_dest};
    // No push-through when full, even if the FIFO pops this cycle.
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    route_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Next-state logic. A new entry is loaded on the same edge it is popped,
    // so back-to-back requests chain with no idle cycle.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_in_d = data_in_q;
        sel_d     = sel_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_in_d = fifo_head.data;
                    sel_d     = fifo_head.dest;
                    hold_d    = HOLD_RELOAD;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_in_d = fifo_head.data;
                    sel_d     = fifo_head.dest;
                    hold_d    = HOLD_RELOAD;
                end else begin
                    // sel intentionally left at the last destination.
                    data_in_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                data_in_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            data_in_q <= 1'b0;
            sel_q     <= CH0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_in_q <= data_in_d;
            sel_q     <= sel_d;
        end
    end

    assign data_in = data_in_q;
    assign sel     = sel_q;
    assign busy    = (state_q == ST_DRIVE);

`ifdef ROUTE_STATS_EN
    logic [7:0] stat_q [4];
    logic [7:0] stat_d [4];
    logic       deliv_done;

    // A delivery completes on the last cycle of its hold window.
    assign deliv_done = (state_q == ST_DRIVE) && (hold_q == '0);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_d[i] = stat_q[i];
        end
        if (deliv_done) begin
            stat_d[sel_q] = sat_inc8(stat_q[sel_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    assign stat_cnt = {stat_q[CH3], stat_q[CH2], stat_q[CH1], stat_q[CH0]};
`endif

endmodule
